// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// buffers {instr, pc+4} in a DEPTH-entry FIFO and drops stale responses
// after a branch redirect.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response straight
// to out_* in the same cycle when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        startin,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        IF_IDWrite,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus_4
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inflight_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc4_mem   [DEPTH];

  logic             w_hs;
  logic             w_rsp;
  logic             w_head_vld;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Request outputs come straight from state registers, never from inputs.
  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc;

  assign w_hs       = (r_state == ST_REQ) && imem_ready;
  assign w_rsp      = (r_state == ST_WAIT) && imem_rvalid;
  assign w_head_vld = (r_count != '0);
  // A redirect flushes the FIFO, so any pop in that cycle is meaningless.
  assign w_pop      = w_head_vld && IF_IDWrite && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = !w_head_vld && w_rsp && !redirect;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed response that the consumer takes immediately never occupies a slot.
  assign w_push      = w_rsp && !redirect && !(w_byp && IF_IDWrite);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Present the FIFO head, or the live response when the FIFO is empty; nop otherwise.
  always_comb begin
    out_valid     = w_head_vld || w_byp;
    out_instr     = 32'h0;
    out_pc_plus_4 = 32'h0;
    if (w_head_vld) begin
      out_instr     = r_instr_mem[r_rd_ptr];
      out_pc_plus_4 = r_pc4_mem[r_rd_ptr];
    end else if (w_byp) begin
      out_instr     = imem_rdata;
      out_pc_plus_4 = r_inflight_pc + 32'd4;
    end
  end
`else
  // Present the FIFO head; nop when empty.
  always_comb begin
    out_valid     = w_head_vld;
    out_instr     = 32'h0;
    out_pc_plus_4 = 32'h0;
    if (w_head_vld) begin
      out_instr     = r_instr_mem[r_rd_ptr];
      out_pc_plus_4 = r_pc4_mem[r_rd_ptr];
    end
  end
`endif

  // Fetch FSM, fetch PC and FIFO bookkeeping; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (startin) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect) begin
      r_pc     <= redirect_pc;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        // An accepted request still owes a response, which must be dropped.
        ST_REQ:  r_state <= imem_ready ? ST_DROP : ST_REQ;
        // A response landing in the redirect cycle is discarded here and now;
        // otherwise wait in DROP for the stale one.
        ST_WAIT,
        ST_DROP: r_state <= imem_rvalid ? ST_REQ : ST_DROP;
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_count < DEPTH_C) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) r_state <= (w_count_nxt < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
        ST_DROP: begin
          if (imem_rvalid) r_state <= ST_REQ;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath storage: in-flight address and FIFO payload carry no reset.
  always_ff @(posedge clk) begin
    if (w_hs) r_inflight_pc <= r_pc;
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata;
      r_pc4_mem[r_wr_ptr]   <= r_inflight_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a variable-latency
// instruction-memory model and a reference PC stream that follows redirects.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        startin = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        IF_IDWrite = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus_4;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .startin      (startin),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .IF_IDWrite   (IF_IDWrite),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc_plus_4(out_pc_plus_4)
  );

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_cons = 0;
  logic [31:0] exp_q[$];
  logic [31:0] key = 32'h0;
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_addr = 32'h0;
  logic        want_first = 1'b0;
  logic [31:0] first_pc4 = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference program stream restarts at pc.
  task automatic refill(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(4 * i));
    want_first = 1'b1;
    first_pc4  = 32'h0;
  endtask

  // One clock: drive inputs at negedge, run memory model and scoreboard.
  task automatic step(input logic rdy, input int lat, input logic redir,
                      input logic [31:0] rpc, input logic ifw, input logic st);
    logic [31:0] e;
    @(negedge clk);
    startin     = st;
    imem_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    IF_IDWrite  = ifw;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (st) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_addr ^ key;
        m_busy      = 1'b0;
      end
    end
    #1;
    if (st) begin
      refill(RST_PC);
    end else begin
      if (!out_valid) begin
        chk("nop_instr", out_instr, 32'h0);
        chk("nop_pc4", out_pc_plus_4, 32'h0);
      end else if (ifw && !redir) begin
        e = exp_q.pop_front();
        exp_q.push_back(exp_q[$] + 32'd4);
        chk("instr", out_instr, e ^ key);
        chk("pc_plus_4", out_pc_plus_4, e + 32'd4);
        n_cons++;
        if (want_first) begin
          first_pc4  = out_pc_plus_4;
          want_first = 1'b0;
        end
      end
      if (imem_req && rdy) begin
        m_busy = 1'b1;
        m_wait = lat;
        m_addr = imem_addr;
      end
      if (redir) refill(rpc);
    end
  endtask

  initial begin
    int c0;
    logic [31:0] rpc;

    // Reset, then check idle outputs.
    step(1'b0, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    c0 = n_cons;
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);

    // Streaming with 1-cycle memory: one instruction per two cycles.
    for (int i = 0; i < 19; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("throughput", 32'(n_cons - c0), 32'd9);

    // Stall: FIFO fills, request stops, head held.
    for (int i = 0; i < 12; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    chk("full_head", out_instr, exp_q[0] ^ key);
    chk("full_head_pc4", out_pc_plus_4, exp_q[0] + 32'd4);

    // Release: four entries drain in four cycles and fetch resumes.
    c0 = n_cons;
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain4", 32'(n_cons - c0), 32'd4);

    // Redirect while a request is in flight; its response must be dropped.
    for (int i = 0; i < 20 && !(m_busy && m_wait == 2); i++)
      step(1'b1, 2, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("found_wait", {31'h0, m_busy}, 32'h1);
    step(1'b1, 2, 1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("redir_flush", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("redir_first", first_pc4, 32'h104);

    // Redirect coincident with response and pop on a nearly full FIFO.
    for (int i = 0; i < 16; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fill_req", {31'h0, imem_req}, 32'h0);
    step(1'b1, 2, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 2, 1'b1, 32'h2000, 1'b1, 1'b0);
    step(1'b0, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("coinc_valid", {31'h0, out_valid}, 32'h0);
    chk("coinc_req", {31'h0, imem_req}, 32'h1);
    chk("coinc_addr", imem_addr, 32'h2000);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("coinc_first", first_pc4, 32'h2004);

    // Reset mid-stream together with a redirect: reset wins.
    step(1'b1, 1, 1'b1, 32'h3000, 1'b1, 1'b1);
    step(1'b0, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mrst_addr", imem_addr, RST_PC);
    chk("mrst_req", {31'h0, imem_req}, 32'h0);
    chk("mrst_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mrst_first", first_pc4, RST_PC + 32'd4);

    // Random latency, stalls and branches.
    key = 32'hC0DE_0000;
    step(1'b1, 1, 1'b1, 32'h4000, 1'b1, 1'b0);
    c0 = n_cons;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      else rpc = $urandom() & 32'h000F_FFFC;
      step($urandom_range(0, 9) < 7, int'($urandom_range(1, 5)),
           $urandom_range(0, 99) < 3, rpc, $urandom_range(0, 9) < 7, 1'b0);
    end
    chk("liveness", {31'h0, (n_cons - c0) > 500}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
